lane_operand_serializer: RTL and testbench

Sequential lane unpacker for FP-style operand preparation. It captures `NUM_OPERANDS` packed operands in one transaction, then emits them lane by lane. Each lane is `operand >> lane*lane_width`, truncated to the format's lane width and zero- or sign-extended to `WIDTH`. It sits between an operand issue stage and a narrow per-lane datapath, and replaces the single-cycle combinational unpack loop with a buffered, handshaked, format-programmable version.

---
 rtl/lane_operand_serializer.sv | 114 +++++++++++
 tb/tb_lane_operand_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_operand_serializer.sv
// Lane operand serializer: captures a bundle of packed operands and emits them one
// lane per cycle, each lane zero- or sign-extended to WIDTH, with valid/ready handshakes.
module lane_operand_serializer #(
    parameter int NUM_OPERANDS = 3,
    parameter int WIDTH        = 64,
    localparam int LIDX_W      = ($clog2(WIDTH / 8) > 0) ? $clog2(WIDTH / 8) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [NUM_OPERANDS*WIDTH-1:0] operands_i,
    input  logic [1:0]                    src_fmt_i,
    input  logic                          sext_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NUM_OPERANDS*WIDTH-1:0] lane_operands_o,
    output logic [LIDX_W-1:0]             lane_idx_o,
    output logic                          last_o
);
    localparam int FMT_MAX   = $clog2(WIDTH / 8);
    localparam int SH_W      = $clog2(WIDTH);
    localparam int LANES_MAX = WIDTH / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                          state_reg, state_next;
    logic [LIDX_W-1:0]               lane_reg, lane_next;
    logic [NUM_OPERANDS*WIDTH-1:0]   ops_reg;
    logic [1:0]                      fmt_reg;
    logic                            sext_reg;
    logic                            capture;

    logic [1:0]                      fmt_eff;
    logic [LIDX_W-1:0]               last_idx;
    logic [SH_W-1:0]                 shamt;
    logic                            busy;

    // Formats wider than WIDTH collapse onto the single full-width lane.
    always_comb begin
        fmt_eff  = (int'(fmt_reg) > FMT_MAX) ? 2'(FMT_MAX) : fmt_reg;
        last_idx = LIDX_W'((LANES_MAX >> fmt_eff) - 1);
        shamt    = SH_W'(lane_reg) << (3 + int'(fmt_eff));
    end

    assign busy        = (state_reg == BUSY);
    assign out_valid_o = busy;
    assign last_o      = busy && (lane_reg == last_idx);
    assign lane_idx_o  = lane_reg;
    assign in_ready_o  = !flush_i && (!busy || (last_o && out_ready_i));

    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        capture    = 1'b0;
        if (flush_i) begin
            state_next = IDLE;
            lane_next  = '0;
        end else if (in_valid_i && in_ready_o) begin
            state_next = BUSY;
            lane_next  = '0;
            capture    = 1'b1;
        end else if (busy && out_ready_i) begin
            if (last_o) begin
                state_next = IDLE;
                lane_next  = '0;
            end else begin
                lane_next = lane_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            lane_reg  <= '0;
            ops_reg   <= '0;
            fmt_reg   <= '0;
            sext_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
            if (capture) begin
                ops_reg  <= operands_i;
                fmt_reg  <= src_fmt_i;
                sext_reg <= sext_i;
            end
        end
    end

    // Every candidate lane width is extended in parallel; fmt_eff picks one.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_op
            logic [WIDTH-1:0] shifted;
            logic [WIDTH-1:0] ext [4];

            assign shifted = ops_reg[gi*WIDTH +: WIDTH] >> shamt;

            for (genvar gf = 0; gf < 4; gf++) begin : g_fmt
                localparam int LW = 8 << gf;
                if (LW < WIDTH) begin : g_narrow
                    assign ext[gf] = sext_reg ? {{(WIDTH-LW){shifted[LW-1]}}, shifted[LW-1:0]}
                                              : {{(WIDTH-LW){1'b0}}, shifted[LW-1:0]};
                end else begin : g_full
                    assign ext[gf] = shifted;
                end
            end

            assign lane_operands_o[gi*WIDTH +: WIDTH] = ext[fmt_eff];
        end
    endgenerate
endmodule

// File: tb/tb_lane_operand_serializer.sv
// Bench for lane_operand_serializer: a 32-bit instance driven from a vector table and a
// 64-bit instance driven by directed sequences and random traffic against a lane-queue model.
module tb_lane_operand_serializer;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 64-bit instance
    logic            flush, in_valid, in_ready, out_valid, out_ready, sext, last;
    logic [1:0]      fmt;
    logic [N*64-1:0] ops, lane_ops;
    logic [2:0]      lane_idx;

    // 32-bit instance
    logic            flush_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s, sext_s, last_s;
    logic [1:0]      fmt_s;
    logic [N*32-1:0] ops_s, lane_ops_s;
    logic [1:0]      lane_idx_s;

    lane_operand_serializer #(.NUM_OPERANDS(N), .WIDTH(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .operands_i(ops), .src_fmt_i(fmt), .sext_i(sext), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .lane_operands_o(lane_ops), .lane_idx_o(lane_idx), .last_o(last)
    );

    lane_operand_serializer #(.NUM_OPERANDS(N), .WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_s), .in_valid_i(in_valid_s), .in_ready_o(in_ready_s),
        .operands_i(ops_s), .src_fmt_i(fmt_s), .sext_i(sext_s), .out_valid_o(out_valid_s),
        .out_ready_i(out_ready_s), .lane_operands_o(lane_ops_s), .lane_idx_o(lane_idx_s), .last_o(last_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the remaining lanes of the bundle in flight, front = on the output now.
    typedef struct {
        logic [N*64-1:0] data;
        int              idx;
        bit              last;
    } lane_t;
    lane_t q[$];
    int    bundles = 0;

    function automatic logic [63:0] ref_lane(input logic [63:0] op, input int f, input bit sx, input int l);
        int lw;
        logic [127:0] mask, v;
        lw   = ((8 << f) > 64) ? 64 : (8 << f);
        mask = (128'd1 << lw) - 128'd1;
        v    = ({64'd0, op} >> (l * lw)) & mask;
        if (sx && v[lw-1]) v = v | ~mask;
        return v[63:0];
    endfunction

    task automatic push_bundle(input logic [N*64-1:0] o, input int f, input bit sx);
        int lw, nl;
        lane_t e;
        lw = ((8 << f) > 64) ? 64 : (8 << f);
        nl = 64 / lw;
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < N; k++) e.data[k*64 +: 64] = ref_lane(o[k*64 +: 64], f, sx, l);
            e.idx  = l;
            e.last = (l == nl - 1);
            q.push_back(e);
        end
        bundles++;
        $display("bundle %0d accepted fmt=%0d sext=%0d lanes=%0d", bundles, f, sx, nl);
    endtask

    // One clock cycle on the 64-bit instance: drive, check against model, advance model.
    task automatic step(input bit iv, input bit ordy, input bit fl,
                        input logic [N*64-1:0] o, input logic [1:0] f, input bit sx);
        bit exp_ready;
        @(negedge clk);
        in_valid = iv; out_ready = ordy; flush = fl; ops = o; fmt = f; sext = sx;
        #1;
        exp_ready = !fl && (q.size() == 0 || (q.size() == 1 && ordy));
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("lane_data", lane_ops, q[0].data);
            check("lane_idx", lane_idx, q[0].idx);
            check("last", last, q[0].last);
        end else begin
            check("last_idle", last, 1'b0);
        end
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) q.delete(0);
            if (iv && exp_ready) push_bundle(o, int'(f), sx);
        end
    endtask

    typedef struct {
        logic [1:0]  fmt;
        bit          sext;
        logic [31:0] op;
        int          nl;
        logic [31:0] exp [4];
    } vec_t;
    vec_t tbl [6];

    function automatic logic [N*64-1:0] rnd_ops();
        logic [N*64-1:0] r;
        for (int i = 0; i < 2 * N; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        tbl[0] = '{2'd1, 1'b0, 32'h12345678, 2, '{32'h00005678, 32'h00001234, 32'h0, 32'h0}};
        tbl[1] = '{2'd1, 1'b1, 32'h80017FFF, 2, '{32'h00007FFF, 32'hFFFF8001, 32'h0, 32'h0}};
        tbl[2] = '{2'd3, 1'b0, 32'hDEADBEEF, 1, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}};
        tbl[3] = '{2'd0, 1'b1, 32'h80FF7F01, 4, '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80}};
        tbl[4] = '{2'd2, 1'b1, 32'h80000000, 1, '{32'h80000000, 32'h0, 32'h0, 32'h0}};
        tbl[5] = '{2'd0, 1'b0, 32'h00FF0080, 4, '{32'h00000080, 32'h0, 32'h000000FF, 32'h0}};

        rst = 1'b1;
        flush = 0; in_valid = 0; out_ready = 0; ops = '0; fmt = 0; sext = 0;
        flush_s = 0; in_valid_s = 0; out_ready_s = 0; ops_s = '0; fmt_s = 0; sext_s = 0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_idx", lane_idx, 0);
        check("rst_data", lane_ops, 0);
        check("rst_out_valid32", out_valid_s, 1'b0);
        check("rst_in_ready32", in_ready_s, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors on the 32-bit instance
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            in_valid_s = 1; out_ready_s = 1; fmt_s = tbl[t].fmt; sext_s = tbl[t].sext;
            ops_s = {64'd0, tbl[t].op};
            #1 check("tbl_in_ready", in_ready_s, 1'b1);
            @(negedge clk);
            in_valid_s = 0;
            for (int l = 0; l < tbl[t].nl; l++) begin
                #1;
                check("tbl_valid", out_valid_s, 1'b1);
                check("tbl_data", lane_ops_s, {64'd0, tbl[t].exp[l]});
                check("tbl_idx", lane_idx_s, l);
                check("tbl_last", last_s, l == tbl[t].nl - 1);
                @(negedge clk);
            end
            #1 check("tbl_idle", out_valid_s, 1'b0);
            $display("vector %0d fmt=%0d sext=%0d op=%h lanes=%0d", t, tbl[t].fmt, tbl[t].sext, tbl[t].op, tbl[t].nl);
        end

        // Backpressure: 8 byte lanes, stall 3 cycles at lane 2
        step(1, 1, 0, rnd_ops(), 2'd0, 1'b1);
        step(0, 1, 0, '0, 0, 0);
        step(0, 1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, 0, 0);
            check("bp_idx", lane_idx, 2);
        end
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0, 0, 0);
        step(0, 1, 0, '0, 0, 0);
        check("bp_done", out_valid, 1'b0);

        // Back-to-back: in_valid held high across two 32-bit-lane bundles
        step(1, 1, 0, rnd_ops(), 2'd2, 1'b0);
        step(1, 1, 0, rnd_ops(), 2'd2, 1'b1);
        step(1, 1, 0, rnd_ops(), 2'd2, 1'b1);
        step(0, 1, 0, '0, 0, 0);
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_idx", lane_idx, 0);
        step(0, 1, 0, '0, 0, 0);
        step(0, 1, 0, '0, 0, 0);

        // Flush at lane 1 together with a new bundle
        step(1, 1, 0, rnd_ops(), 2'd0, 1'b0);
        step(0, 1, 0, '0, 0, 0);
        step(1, 1, 1, rnd_ops(), 2'd1, 1'b0);
        step(0, 1, 0, '0, 0, 0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);

        // Asynchronous reset mid-bundle
        step(1, 1, 0, rnd_ops() | {N{64'h8080808080808080}}, 2'd1, 1'b1);
        step(0, 0, 0, '0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", lane_ops, 0);
        check("arst_idx", lane_idx, 0);
        check("arst_last", last, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                 rnd_ops(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
